// File: rtl/hall_commutator_if.sv
// rtl/hall_commutator_if.sv - hall input / phase drive signal bundle for hall_commutator
interface hall_commutator_if #(
    parameter int PERIOD_WIDTH = 16
);
    logic                    enable;
    logic                    dir;
    logic                    fault_clear;
    logic [2:0]              h;
    logic [2:0]              u;
    logic [2:0]              z;
    logic                    fault;
    logic                    step;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;

    modport master (
        output enable, dir, fault_clear, h,
        input  u, z, fault, step, period, period_valid
    );

    modport slave (
        input  enable, dir, fault_clear, h,
        output u, z, fault, step, period, period_valid
    );
endinterface

// File: rtl/hall_commutator.sv
// rtl/hall_commutator.sv - six-step BLDC hall commutator with glitch filter and fault latch
// Define HALL_PERIOD_EN to build the commutation-period counter; otherwise period/period_valid read 0.
module hall_commutator #(
    parameter int FILTER_CYCLES = 4,
    parameter int FAULT_LIMIT   = 3,
    parameter int PERIOD_WIDTH  = 16
) (
    input logic              clock,
    input logic              reset,
    hall_commutator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    localparam logic [7:0] FILT  = 8'(FILTER_CYCLES);
    localparam logic [3:0] LIMIT = 4'(FAULT_LIMIT);

    state_t     state, state_next;
    logic [2:0] sync1, sync2, cand, hf, hf_prev;
    logic [7:0] run_cnt, run_next;
    logic [3:0] bad_cnt, bad_cnt_next;
    logic [2:0] sec_now, sec_prev;
    logic       now_valid, prev_valid, adjacent, changed, legal, bad;
    logic [2:0] u_f, z_f, u_next, z_next;

    // Sector index 0..5 in forward rotation order; 7 marks an invalid code.
    function automatic logic [2:0] sector(input logic [2:0] code);
        case (code)
            3'b101:  sector = 3'd0;
            3'b100:  sector = 3'd1;
            3'b110:  sector = 3'd2;
            3'b010:  sector = 3'd3;
            3'b011:  sector = 3'd4;
            3'b001:  sector = 3'd5;
            default: sector = 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] next_sector(input logic [2:0] s);
        next_sector = (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    always_comb begin
        run_next = 8'd1;
        if (sync2 == cand)
            run_next = (run_cnt == 8'd255) ? 8'd255 : run_cnt + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1   <= 3'b000;
            sync2   <= 3'b000;
            cand    <= 3'b000;
            run_cnt <= 8'd0;
            hf      <= 3'b000;
            hf_prev <= 3'b000;
        end else begin
            sync1   <= bus.h;
            sync2   <= sync1;
            cand    <= sync2;
            run_cnt <= run_next;
            if (run_next >= FILT)
                hf <= sync2;
            hf_prev <= hf;
        end
    end

    // A change of hf is seen for exactly one cycle as hf != hf_prev.
    always_comb begin
        sec_now    = sector(hf);
        sec_prev   = sector(hf_prev);
        now_valid  = (sec_now != 3'd7);
        prev_valid = (sec_prev != 3'd7);
        adjacent   = (sec_now == next_sector(sec_prev)) || (sec_prev == next_sector(sec_now));
        changed    = (hf != hf_prev);
        legal      = changed && now_valid && prev_valid && adjacent;
        bad        = changed && (!now_valid || (prev_valid && !adjacent));
    end

    always_comb begin
        state_next   = state;
        bad_cnt_next = bad_cnt;
        case (state)
            IDLE: if (bus.enable) state_next = RUN;
            RUN: begin
                if (bad)
                    bad_cnt_next = bad_cnt + 4'd1;
                else if (legal)
                    bad_cnt_next = 4'd0;
                if (bad && bad_cnt_next >= LIMIT)
                    state_next = FAULT;
                else if (!bus.enable)
                    state_next = IDLE;
            end
            FAULT: begin
                if (bus.fault_clear) begin
                    state_next   = IDLE;
                    bad_cnt_next = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        u_f = 3'b000;
        z_f = 3'b000;
        case (hf)
            3'b101: begin u_f = 3'b100; z_f = 3'b001; end
            3'b100: begin u_f = 3'b100; z_f = 3'b010; end
            3'b110: begin u_f = 3'b010; z_f = 3'b100; end
            3'b010: begin u_f = 3'b010; z_f = 3'b001; end
            3'b011: begin u_f = 3'b001; z_f = 3'b010; end
            3'b001: begin u_f = 3'b001; z_f = 3'b100; end
            default: ;
        endcase
        u_next = 3'b000;
        z_next = 3'b111;
        if (state_next == RUN && now_valid) begin
            u_next = bus.dir ? ~(u_f | z_f) : u_f;
            z_next = z_f;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bad_cnt   <= 4'd0;
            bus.u     <= 3'b000;
            bus.z     <= 3'b111;
            bus.fault <= 1'b0;
            bus.step  <= 1'b0;
        end else begin
            state     <= state_next;
            bad_cnt   <= bad_cnt_next;
            bus.u     <= u_next;
            bus.z     <= z_next;
            bus.fault <= (state_next == FAULT);
            bus.step  <= legal && (state == RUN);
        end
    end

`ifdef HALL_PERIOD_EN
    localparam logic [PERIOD_WIDTH-1:0] PMAX = '1;

    logic [PERIOD_WIDTH-1:0] pcount;
    logic                    have_step;

    // have_step marks that the current RUN stretch has a reference step to measure from.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcount           <= '0;
            have_step        <= 1'b0;
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
        end else if (state_next != RUN) begin
            pcount           <= '0;
            have_step        <= 1'b0;
            bus.period_valid <= 1'b0;
        end else if (legal && state == RUN) begin
            bus.period       <= pcount;
            bus.period_valid <= have_step && (pcount != PMAX);
            have_step        <= 1'b1;
            pcount           <= {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
        end else if (pcount != PMAX) begin
            pcount <= pcount + 1'b1;
            if (pcount == PMAX - 1'b1) begin
                bus.period       <= PMAX;
                bus.period_valid <= 1'b0;
            end
        end
    end
`else
    assign bus.period       = {PERIOD_WIDTH{1'b0}};
    assign bus.period_valid = 1'b0;
`endif
endmodule
